// File: rtl/sha256_digest_serializer.sv
// SHA-256 digest serializer: captures the 256-bit digest on the rising edge
// of hash_done and streams it out over an 8-bit valid/ready port, either as
// 32 raw bytes or 64 ASCII hex characters, most significant first.
module sha256_digest_serializer #(
   parameter bit HEX_UPPER = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [255:0] hash_in,
   input  logic         hash_done,
   input  logic         hex_mode,
   input  logic         abort,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy,
   output logic         overrun
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [255:0] shift_q, shift_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         mode_q, mode_d;
   logic         done_prev_q, done_prev_d;
   logic         overrun_q, overrun_d;

   logic         send;
   logic         cap_ev;
   logic         last;
   logic         hs;
   logic [6:0]   len_m1;
   logic [3:0]   nib;
   logic [7:0]   hex_chr;

   // Output view of the current head of the shift register
   always_comb begin
      send    = (state_q == S_SEND);
      cap_ev  = hash_done & ~done_prev_q;
      len_m1  = mode_q ? 7'd63 : 7'd31;
      last    = send && (cnt_q == len_m1);
      hs      = send & out_ready;
      nib     = shift_q[255:252];
      // Letters start at 'a'/'A' for nibble 10, hence the -10 offset baked in
      if (nib < 4'd10) hex_chr = 8'h30 + {4'h0, nib};
      else             hex_chr = (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nib};
      out_valid = send;
      busy      = send;
      out_last  = last;
      overrun   = overrun_q;
      out_data  = send ? (mode_q ? hex_chr : shift_q[255:248]) : 8'h00;
   end

   // Next-state: abort beats handshake and capture; a capture on the final
   // handshake chains straight into the next stream without an idle gap
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      overrun_d   = overrun_q;
      done_prev_d = hash_done;
      if (abort) begin
         state_d   = S_IDLE;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cap_ev) begin
                  shift_d = hash_in;
                  mode_d  = hex_mode;
                  cnt_d   = 7'd0;
                  state_d = S_SEND;
               end
            end
            default: begin
               if (hs) begin
                  if (last) begin
                     cnt_d = 7'd0;
                     if (cap_ev) begin
                        shift_d = hash_in;
                        mode_d  = hex_mode;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     shift_d = mode_q ? {shift_q[251:0], 4'h0} : {shift_q[247:0], 8'h00};
                     cnt_d   = cnt_q + 7'd1;
                  end
               end
               if (cap_ev && !(hs && last)) overrun_d = 1'b1;
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         done_prev_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         done_prev_q <= done_prev_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed bench for sha256_digest_serializer: raw/hex streams, backpressure,
// overrun, back-to-back capture, abort and asynchronous reset.
module tb_sha256_digest_serializer;

   localparam logic [255:0] DG1 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DG2 = 256'h0123456789abcdeffedcba9876543210_00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] hash_in = '0;
   logic         hash_done = 1'b0;
   logic         hex_mode = 1'b0;
   logic         abort = 1'b0;
   logic         out_ready = 1'b0;
   logic [7:0]   out_data, up_out_data;
   logic         out_valid, out_last, busy, overrun;
   logic         up_out_valid, up_out_last, up_busy, up_overrun;

   int chk_cnt = 0;
   int pass_cnt = 0;

   sha256_digest_serializer #(.HEX_UPPER(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_done(hash_done),
      .hex_mode(hex_mode), .abort(abort), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun));

   sha256_digest_serializer #(.HEX_UPPER(1'b1)) u_dut_up (
      .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_done(hash_done),
      .hex_mode(hex_mode), .abort(abort), .out_data(up_out_data), .out_valid(up_out_valid),
      .out_ready(out_ready), .out_last(up_out_last), .busy(up_busy), .overrun(up_overrun));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference byte/character i of a digest stream
   function automatic logic [7:0] exp_byte(input logic [255:0] dg, input bit hex, input int i);
      string hx;
      logic [3:0] nb;
      hx = "0123456789abcdef";
      if (!hex) return dg[255-8*i -: 8];
      nb = dg[255-4*i -: 4];
      return hx[nb];
   endfunction

   // Raise hash_done for one cycle; returns at the negedge after the capture edge
   task automatic kick(input logic [255:0] dg, input bit hex);
      hash_in   = dg;
      hex_mode  = hex;
      hash_done = 1'b1;
      @(negedge clk);
      hash_done = 1'b0;
   endtask

   // Receive a stream, checking bytes, out_last and stability during stalls.
   // stop_at >= 0 returns early when that many bytes have been taken;
   // edge_at >= 0 raises a done edge on the handshake of that byte.
   task automatic recv(input logic [255:0] dg, input bit hex, input bit rnd,
                       input int stop_at, input int edge_at,
                       input logic [255:0] dg2, input bit hex2);
      int n, got, stall, cyc;
      bit fired, pv, phs, hs;
      logic [7:0] pd;
      logic pl;
      n = hex ? 64 : 32;
      got = 0; stall = 0; cyc = 0;
      fired = 0; pv = 0; phs = 0; pd = '0; pl = 1'b0;
      while (got < n && cyc < 3000) begin
         if (got == stop_at) return;
         if (fired) hash_done = 1'b0;
         if (rnd) begin
            if (got == 5 && stall < 10) begin
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            out_ready = 1'b1;
         end
         if (got == edge_at && !fired) begin
            hash_in   = dg2;
            hex_mode  = hex2;
            hash_done = 1'b1;
            fired     = 1;
         end
         if (pv && !phs) begin
            chk("hold_data", out_data, pd);
            chk("hold_last", out_last, pl);
            chk("hold_valid", out_valid, 1);
         end
         if (!rnd) chk("valid_run", out_valid, 1);
         hs = out_valid & out_ready;
         if (hs) begin
            chk($sformatf("byte%0d", got), out_data, exp_byte(dg, hex, got));
            chk($sformatf("last%0d", got), out_last, (got == n-1));
            got++;
         end
         pv = out_valid; phs = hs; pd = out_data; pl = out_last;
         @(negedge clk);
         cyc++;
      end
      if (stop_at < 0) chk("stream_len", got, n);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_last"}, out_last, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Raw stream, ready tied high
      kick(DG1, 1'b0);
      chk("raw_first", out_data, 8'hba);
      recv(DG1, 1'b0, 1'b0, -1, -1, '0, 1'b0);
      chk_idle("raw_end");

      // Hex stream, both letter cases
      kick(DG1, 1'b1);
      chk("hex_first", out_data, 8'h62);
      chk("hex_first_upper", up_out_data, 8'h42);
      chk("up_flags", {up_out_valid, up_out_last, up_busy, up_overrun}, 4'b1010);
      recv(DG1, 1'b1, 1'b0, -1, -1, '0, 1'b0);
      chk_idle("hex_end");

      // Random backpressure with a 10-cycle stall on byte 5
      kick(DG1, 1'b0);
      recv(DG1, 1'b0, 1'b1, -1, -1, '0, 1'b0);
      out_ready = 1'b1;
      chk_idle("bp_end");

      // Second done edge mid-stream is ignored and flags overrun
      kick(DG1, 1'b0);
      recv(DG1, 1'b0, 1'b0, -1, 10, DG2, 1'b0);
      hash_done = 1'b0;
      chk("ovr_set", overrun, 1);
      chk_idle("ovr_end");

      // Edge on the final handshake chains a hex stream with no gap
      kick(DG1, 1'b0);
      recv(DG1, 1'b0, 1'b0, -1, 31, DG2, 1'b1);
      hash_done = 1'b0;
      chk("b2b_valid", out_valid, 1);
      recv(DG2, 1'b1, 1'b0, -1, -1, '0, 1'b0);
      chk("b2b_overrun", overrun, 1);
      chk_idle("b2b_end");

      // Abort together with a done edge at byte 7
      kick(DG1, 1'b0);
      recv(DG1, 1'b0, 1'b0, 7, -1, '0, 1'b0);
      abort = 1'b1;
      hash_done = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      hash_done = 1'b0;
      chk_idle("abort");
      chk("abort_overrun", overrun, 0);
      repeat (3) @(negedge clk);
      chk("abort_edge_dropped", out_valid, 0);

      // Asynchronous reset mid-stream, then done already high at release
      kick(DG2, 1'b1);
      recv(DG2, 1'b1, 1'b0, 20, -1, '0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst_data", out_data, 0);
      chk("arst_overrun", overrun, 0);
      hash_in   = DG1;
      hex_mode  = 1'b0;
      hash_done = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      hash_done = 1'b0;
      chk("rel_valid", out_valid, 1);
      recv(DG1, 1'b0, 1'b0, -1, -1, '0, 1'b0);
      chk_idle("rel_end");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got %0d passed of %0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
